// File: rtl/ecg_infer_seq_if.sv
// Result handshake bundle between the ECG inference sequencer and its consumer.
interface ecg_infer_seq_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        res_data;
    logic [ADDR_W-1:0] res_addr;

    modport master (output res_valid, output res_data, output res_addr, input res_ready);
    modport slave  (input res_valid, input res_data, input res_addr, output res_ready);
endinterface

// File: rtl/ecg_infer_seq.sv
// Sequencer for the ECG classifier: walks ROM windows, waits out the pipeline, hands results downstream.
// Optional abnormal-beat counter built only when ECG_ABN_COUNT_EN is defined.
module ecg_infer_seq #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned PIPE_LAT   = 8,
    parameter logic [7:0]  ABN_THRESH = 8'd128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] sel,
    output logic              nn_en,
    input  logic [7:0]        nn_out,
    ecg_infer_seq_if.master   res,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   abn_count
);
    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  wcnt;
    logic [ADDR_W:0]   remaining;
    logic              res_valid_q;
    logic [7:0]        res_data_q;
    logic [ADDR_W-1:0] res_addr_q;
    logic [ADDR_W-1:0] sel_nxt;
    logic              capture;

    // sel doubles as the current window address; it is only ever advanced on a transfer
    assign sel_nxt = (sel == ADDR_W'(DEPTH - 1)) ? '0 : sel + 1'b1;
    assign capture = (state == S_WAIT) && (wcnt == '0) && !abort;
    assign busy    = (state != S_IDLE);

    assign res.res_valid = res_valid_q;
    assign res.res_data  = res_data_q;
    assign res.res_addr  = res_addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            remaining   <= '0;
            sel         <= '0;
            nn_en       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            done        <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state       <= S_IDLE;
            nn_en       <= 1'b0;
            res_valid_q <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    if (count != '0) begin
                        sel       <= first_addr;
                        remaining <= count;
                        nn_en     <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    wcnt  <= CNT_W'(PIPE_LAT - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt == '0) begin
                        res_data_q  <= nn_out;
                        res_addr_q  <= sel;
                        remaining   <= remaining - 1'b1;
                        nn_en       <= 1'b0;
                        res_valid_q <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_HOLD: if (res.res_ready) begin
                    res_valid_q <= 1'b0;
                    if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        sel   <= sel_nxt;
                        nn_en <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ECG_ABN_COUNT_EN
    // Cleared on any accepted start (including count==0), saturating at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abn_count <= '0;
        end else if (state == S_IDLE && start) begin
            abn_count <= '0;
        end else if (capture && nn_out >= ABN_THRESH && abn_count != (ADDR_W+1)'(DEPTH)) begin
            abn_count <= abn_count + 1'b1;
        end
    end
`else
    assign abn_count = '0;
`endif

endmodule

// File: tb/tb_ecg_infer_seq.sv
// Directed self-checking bench for ecg_infer_seq (PIPE_LAT=8, DEPTH=64).
module tb_ecg_infer_seq;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [AW-1:0] first_addr, sel, res_addr;
    logic [AW:0]   count, abn_count;
    logic          nn_en, res_valid, busy, done;
    logic [7:0]    nn_out, res_data;
    logic [7:0]    nn_tab [64];
    int            tests = 0, fails = 0, done_cnt = 0;

    ecg_infer_seq_if #(.ADDR_W(AW)) rif ();

    ecg_infer_seq #(.ADDR_W(AW), .DEPTH(64), .PIPE_LAT(8), .ABN_THRESH(8'd128)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .first_addr(first_addr), .count(count), .sel(sel), .nn_en(nn_en),
        .nn_out(nn_out), .res(rif), .busy(busy), .done(done), .abn_count(abn_count)
    );

    always #5 clk = ~clk;
    assign nn_out    = nn_tab[sel];
    assign res_valid = rif.res_valid;
    assign res_data  = rif.res_data;
    assign res_addr  = rif.res_addr;

    always @(posedge clk) if (done) done_cnt++;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 64; i++) nn_tab[i] = v;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin cyc = i; break; end
            step();
        end
    endtask

    task automatic kick(input logic [AW-1:0] fa, input logic [AW:0] cnt);
        first_addr = fa; count = cnt; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (sel !== '0) begin fails++; $display("FAIL reset_sel got %0d exp 0", sel); end
        tests++; if (nn_en !== 1'b0) begin fails++; $display("FAIL reset_nn_en got %b exp 0", nn_en); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", res_valid); end
        tests++; if (res_data !== 8'h00 || res_addr !== '0) begin fails++; $display("FAIL reset_res got %h/%0d exp 00/0", res_data, res_addr); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        tests++; if (abn_count !== '0) begin fails++; $display("FAIL reset_abn got %0d exp 0", abn_count); end
    endtask

    task automatic test_single();
        int n, en_cnt;
        fill(8'h3C); rif.res_ready = 1'b1;
        kick(6'd5, 7'd1);
        n = 0; en_cnt = 0;
        while (!res_valid && n < 40) begin
            if (nn_en && sel == 6'd5 && busy) en_cnt++;
            step(); n++;
        end
        tests++; if (n !== 9) begin fails++; $display("FAIL single_latency got %0d exp 9", n); end
        tests++; if (en_cnt !== 9) begin fails++; $display("FAIL single_nn_en_cycles got %0d exp 9", en_cnt); end
        tests++; if (res_data !== 8'h3C || res_addr !== 6'd5) begin fails++; $display("FAIL single_result got %h/%0d exp 3c/5", res_data, res_addr); end
        tests++; if (nn_en !== 1'b0) begin fails++; $display("FAIL single_hold_en got %b exp 0", nn_en); end
        step();
        tests++; if (done !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL single_done got done=%b valid=%b exp 1/0", done, res_valid); end
        step();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL single_idle got busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        int cyc, d0;
        exp_a[0] = 6'd62; exp_a[1] = 6'd63; exp_a[2] = 6'd0; exp_a[3] = 6'd1;
        fill(8'h42); rif.res_ready = 1'b1; d0 = done_cnt;
        kick(6'd62, 7'd4);
        for (int k = 0; k < 4; k++) begin
            wait_valid(cyc);
            tests++; if (cyc !== 9) begin fails++; $display("FAIL wrap_spacing[%0d] got %0d exp 9", k, cyc); end
            tests++; if (res_addr !== exp_a[k]) begin fails++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", k, res_addr, exp_a[k]); end
            step();
        end
        repeat (4) step();
        tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL wrap_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        int cyc, bad;
        fill(8'h00); nn_tab[20] = 8'h11; nn_tab[21] = 8'h22;
        rif.res_ready = 1'b0;
        kick(6'd20, 7'd2);
        wait_valid(cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!res_valid || res_data !== 8'h11 || res_addr !== 6'd20 || nn_en || sel !== 6'd20) bad++;
            step();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL bp_hold_stable got %0d bad cycles exp 0", bad); end
        rif.res_ready = 1'b1;
        step();
        tests++; if (sel !== 6'd21 || nn_en !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL bp_second_issue got sel=%0d en=%b v=%b exp 21/1/0", sel, nn_en, res_valid); end
        wait_valid(cyc);
        tests++; if (cyc !== 9 || res_data !== 8'h22 || res_addr !== 6'd21) begin fails++; $display("FAIL bp_second_result got %0d %h/%0d exp 9 22/21", cyc, res_data, res_addr); end
        step();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_count0_and_busy_start();
        int cyc, d0, bad;
        fill(8'h77); rif.res_ready = 1'b1;
        first_addr = 6'd9; count = 7'd0; start = 1'b1;
        step();
        start = 1'b0;
        tests++; if (done !== 1'b1 || busy !== 1'b1 || nn_en !== 1'b0) begin fails++; $display("FAIL count0_done got done=%b busy=%b en=%b exp 1/1/0", done, busy, nn_en); end
        step();
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL count0_idle got done=%b busy=%b exp 0/0", done, busy); end
        d0 = done_cnt;
        kick(6'd30, 7'd2);
        step(); step();
        first_addr = 6'd0; count = 7'd5; start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(cyc);
        tests++; if (res_addr !== 6'd30) begin fails++; $display("FAIL busy_start_r0 got %0d exp 30", res_addr); end
        step();
        wait_valid(cyc);
        tests++; if (res_addr !== 6'd31) begin fails++; $display("FAIL busy_start_r1 got %0d exp 31", res_addr); end
        step();
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (res_valid || busy) bad++;
        end
        tests++; if (bad !== 0 || done_cnt - d0 !== 1) begin fails++; $display("FAIL busy_start_len got bad=%0d dones=%0d exp 0/1", bad, done_cnt - d0); end
    endtask

    task automatic test_abort();
        int d0;
        fill(8'h55); rif.res_ready = 1'b1; d0 = done_cnt;
        kick(6'd40, 7'd3);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++; if (busy !== 1'b0 || res_valid !== 1'b0 || nn_en !== 1'b0) begin fails++; $display("FAIL abort_idle got busy=%b v=%b en=%b exp 0/0/0", busy, res_valid, nn_en); end
        tests++; if (res_data !== 8'h77 || res_addr !== 6'd31) begin fails++; $display("FAIL abort_retain got %h/%0d exp 77/31", res_data, res_addr); end
        repeat (12) step();
        tests++; if (done_cnt !== d0 || res_valid !== 1'b0) begin fails++; $display("FAIL abort_no_done got dones=%0d v=%b exp 0/0", done_cnt - d0, res_valid); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        fill(8'hA5); rif.res_ready = 1'b0;
        kick(6'd50, 7'd2);
        wait_valid(cyc);
        tests++; if (cyc !== 9 || res_data !== 8'hA5) begin fails++; $display("FAIL rstmid_pre got %0d %h exp 9 a5", cyc, res_data); end
        #1 reset = 1'b0;
        #1;
        tests++; if (sel !== '0 || nn_en !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl got sel=%0d en=%b v=%b busy=%b done=%b exp all 0", sel, nn_en, res_valid, busy, done); end
        tests++; if (res_data !== 8'h00 || res_addr !== '0 || abn_count !== '0) begin fails++; $display("FAIL rstmid_data got %h/%0d/%0d exp 00/0/0", res_data, res_addr, abn_count); end
        step();
        reset = 1'b1; rif.res_ready = 1'b1;
        step();
    endtask

    task automatic test_abn_count();
        logic [7:0] exp_d [3];
        int cyc;
`ifdef ECG_ABN_COUNT_EN
        logic [AW:0] exp_abn = 7'd2;
`else
        logic [AW:0] exp_abn = 7'd0;
`endif
        exp_d[0] = 8'd200; exp_d[1] = 8'd10; exp_d[2] = 8'd128;
        fill(8'd0); nn_tab[10] = exp_d[0]; nn_tab[11] = exp_d[1]; nn_tab[12] = exp_d[2];
        rif.res_ready = 1'b1;
        kick(6'd10, 7'd3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(cyc);
            tests++; if (cyc !== 9 || res_data !== exp_d[k]) begin fails++; $display("FAIL abn_data[%0d] got %0d %0d exp 9 %0d", k, cyc, res_data, exp_d[k]); end
            step();
        end
        tests++; if (done !== 1'b1 || abn_count !== exp_abn) begin fails++; $display("FAIL abn_count got done=%b cnt=%0d exp 1/%0d", done, abn_count, exp_abn); end
        step();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        first_addr = '0; count = '0; rif.res_ready = 1'b0;
        fill(8'h00);
        step(); step();
        test_reset();
        reset = 1'b1;
        step();
        test_single();
        test_wrap();
        test_backpressure();
        test_count0_and_busy_start();
        test_abort();
        test_reset_mid();
        test_abn_count();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
